icache_responder: RTL and testbench



---
 rtl/icache_pkg.sv | 10 +
 rtl/icache_array.sv | 41 ++++
 rtl/icache_responder.sv | 97 +++++++++
 tb/tb_icache_responder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: shared geometry defaults, derived address-field widths and FSM states for the icache responder.
package icache_pkg;
    localparam int NUM_LINES  = 64;
    localparam int LINE_WORDS = 4;
    localparam int WORD_W     = $clog2(LINE_WORDS);
    localparam int IDX_W      = $clog2(NUM_LINES);
    localparam int OFF_W      = WORD_W + 2;
    localparam int TAG_W      = 32 - IDX_W - OFF_W;
    typedef enum logic [1:0] {IDLE, MISS_REQ, MISS_FILL} state_e;
endpackage

// File: rtl/icache_array.sv
// icache_array: direct-mapped valid/tag/data storage with a combinational read port and one write port.
module icache_array #(
    parameter int NUM_LINES  = icache_pkg::NUM_LINES,
    parameter int LINE_WORDS = icache_pkg::LINE_WORDS,
    parameter int TW         = icache_pkg::TAG_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [$clog2(NUM_LINES)-1:0]  rd_idx_i,
    input  logic [$clog2(LINE_WORDS)-1:0] rd_word_i,
    output logic                          rd_valid_o,
    output logic [TW-1:0]                 rd_tag_o,
    output logic [31:0]                   rd_data_o,
    input  logic                          wr_word_en_i,
    input  logic [$clog2(NUM_LINES)-1:0]  wr_idx_i,
    input  logic [$clog2(LINE_WORDS)-1:0] wr_word_i,
    input  logic [31:0]                   wr_data_i,
    input  logic                          wr_tag_en_i,
    input  logic [TW-1:0]                 wr_tag_i,
    input  logic                          inv_i
);
    logic [NUM_LINES-1:0] valid_q;
    logic [TW-1:0]        tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES][LINE_WORDS];

    // Invalidate-all takes priority over a coincident line completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) valid_q <= '0;
        else if (inv_i) valid_q <= '0;
        else if (wr_tag_en_i) valid_q[wr_idx_i] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_word_en_i) data_q[wr_idx_i][wr_word_i] <= wr_data_i;
        if (wr_tag_en_i) tag_q[wr_idx_i] <= wr_tag_i;
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i][rd_word_i];
endmodule

// File: rtl/icache_responder.sv
// icache_responder: direct-mapped instruction cache answering fetch requests and refilling lines from memory.
module icache_responder #(
    parameter int NUM_LINES  = icache_pkg::NUM_LINES,
    parameter int LINE_WORDS = icache_pkg::LINE_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        icache_en_i,
    input  logic [31:0] icache_addr_i,
    output logic [31:0] icache_rdata_o,
    output logic        icache_rvalid_o,
    input  logic        abort_i,
    input  logic        inv_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);
    import icache_pkg::*;
    localparam int WW = $clog2(LINE_WORDS);
    localparam int IW = $clog2(NUM_LINES);
    localparam int OW = WW + 2;
    localparam int TW = 32 - IW - OW;

    state_e        state_q, state_d;
    logic          req_valid_q, req_valid_d;
    logic [31:0]   req_addr_q, req_addr_d;
    logic [31:0]   fill_addr_q, fill_addr_d;
    logic [WW-1:0] beat_q, beat_d;
    logic          rd_valid, hit, last, fill_beat;
    logic [TW-1:0] rd_tag;
    logic [31:0]   rd_data;

    icache_array #(.NUM_LINES(NUM_LINES), .LINE_WORDS(LINE_WORDS), .TW(TW)) u_array (
        .clk          (clk),
        .rst          (rst),
        .rd_idx_i     (req_addr_q[OW +: IW]),
        .rd_word_i    (req_addr_q[2 +: WW]),
        .rd_valid_o   (rd_valid),
        .rd_tag_o     (rd_tag),
        .rd_data_o    (rd_data),
        .wr_word_en_i (fill_beat),
        .wr_idx_i     (fill_addr_q[OW +: IW]),
        .wr_word_i    (beat_q),
        .wr_data_i    (mem_rdata_i),
        .wr_tag_en_i  (fill_beat && last),
        .wr_tag_i     (fill_addr_q[OW + IW +: TW]),
        .inv_i        (inv_i)
    );

    assign hit       = state_q == IDLE && req_valid_q && rd_valid && rd_tag == req_addr_q[OW + IW +: TW];
    assign last      = beat_q == WW'(LINE_WORDS - 1);
    assign fill_beat = state_q == MISS_FILL && mem_rvalid_i;

    assign icache_rvalid_o = hit;
    assign icache_rdata_o  = hit ? rd_data : '0;
    assign mem_req_o       = state_q == MISS_REQ;
    assign mem_addr_o      = state_q == MISS_REQ ? fill_addr_q : '0;

    // The refill line address is latched separately so new requests can land in req_addr mid-refill.
    always_comb begin
        req_valid_d = icache_en_i ? 1'b1 : (abort_i || hit) ? 1'b0 : req_valid_q;
        req_addr_d  = icache_en_i ? icache_addr_i : req_addr_q;
        state_d     = state_q;
        fill_addr_d = fill_addr_q;
        beat_d      = beat_q;
        if (state_q == IDLE && req_valid_q && !hit && !icache_en_i && !abort_i) begin
            state_d     = MISS_REQ;
            fill_addr_d = {req_addr_q[31:OW], OW'(0)};
        end
        if (state_q == MISS_REQ && mem_gnt_i) begin
            state_d = MISS_FILL;
            beat_d  = '0;
        end
        if (fill_beat) begin
            beat_d  = last ? '0 : beat_q + 1'b1;
            state_d = last ? IDLE : MISS_FILL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            fill_addr_q <= '0;
            beat_q      <= '0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            fill_addr_q <= fill_addr_d;
            beat_q      <= beat_d;
        end
    end
endmodule

// File: tb/tb_icache_responder.sv
// tb_icache_responder: directed self-checking bench for icache_responder.
module tb_icache_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        icache_en_i = 1'b0;
    logic [31:0] icache_addr_i = '0;
    logic [31:0] icache_rdata_o;
    logic        icache_rvalid_o;
    logic        abort_i = 1'b0;
    logic        inv_i = 1'b0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    int          errors = 0;
    int          checks = 0;

    icache_responder dut (
        .clk             (clk),
        .rst             (rst),
        .icache_en_i     (icache_en_i),
        .icache_addr_i   (icache_addr_i),
        .icache_rdata_o  (icache_rdata_o),
        .icache_rvalid_o (icache_rvalid_o),
        .abort_i         (abort_i),
        .inv_i           (inv_i),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_gnt_i       (mem_gnt_i),
        .mem_rvalid_i    (mem_rvalid_i),
        .mem_rdata_i     (mem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic [31:0] a);
        icache_en_i   = 1'b1;
        icache_addr_i = a;
        tick();
        icache_en_i   = 1'b0;
    endtask

    task automatic grant();
        mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = d;
        tick();
        mem_rvalid_i = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_rvalid", 32'(icache_rvalid_o), 32'd0);
        chk("rst_rdata", icache_rdata_o, 32'h0);
        chk("rst_memreq", 32'(mem_req_o), 32'd0);
        chk("rst_memaddr", mem_addr_o, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        // cold miss
        request(32'h0000_0104);
        chk("cold_lookup_rvalid", 32'(icache_rvalid_o), 32'd0);
        tick();
        chk("cold_memreq", 32'(mem_req_o), 32'd1);
        chk("cold_memaddr", mem_addr_o, 32'h0000_0100);
        tick();
        chk("cold_memreq_held", 32'(mem_req_o), 32'd1);
        chk("cold_memaddr_held", mem_addr_o, 32'h0000_0100);
        grant();
        chk("cold_fill_noreq", 32'(mem_req_o), 32'd0);
        beat(32'hA0);
        beat(32'hA1);
        tick();
        beat(32'hA2);
        chk("cold_fill_norvalid", 32'(icache_rvalid_o), 32'd0);
        beat(32'hA3);
        chk("cold_rvalid", 32'(icache_rvalid_o), 32'd1);
        chk("cold_rdata", icache_rdata_o, 32'hA1);
        tick();
        chk("cold_rvalid_single", 32'(icache_rvalid_o), 32'd0);
        // hit
        request(32'h0000_010C);
        chk("hit_rvalid", 32'(icache_rvalid_o), 32'd1);
        chk("hit_rdata", icache_rdata_o, 32'hA3);
        chk("hit_noreq", 32'(mem_req_o), 32'd0);
        tick();
        chk("hit_after_rvalid", 32'(icache_rvalid_o), 32'd0);
        chk("hit_after_noreq", 32'(mem_req_o), 32'd0);
        // abort mid-fill
        request(32'h0000_0200);
        tick();
        chk("abort_memaddr", mem_addr_o, 32'h0000_0200);
        grant();
        beat(32'hB0);
        abort_i = 1'b1;
        beat(32'hB1);
        abort_i = 1'b0;
        beat(32'hB2);
        beat(32'hB3);
        chk("abort_no_rvalid", 32'(icache_rvalid_o), 32'd0);
        tick();
        chk("abort_no_rvalid2", 32'(icache_rvalid_o), 32'd0);
        chk("abort_no_refetch", 32'(mem_req_o), 32'd0);
        request(32'h0000_0200);
        chk("abort_rehit_rvalid", 32'(icache_rvalid_o), 32'd1);
        chk("abort_rehit_rdata", icache_rdata_o, 32'hB0);
        tick();
        // re-request during fill
        request(32'h0000_0300);
        tick();
        chk("rereq_memaddr", mem_addr_o, 32'h0000_0300);
        grant();
        beat(32'hC0);
        icache_en_i   = 1'b1;
        icache_addr_i = 32'h0000_0104;
        beat(32'hC1);
        icache_en_i   = 1'b0;
        beat(32'hC2);
        beat(32'hC3);
        chk("rereq_rvalid", 32'(icache_rvalid_o), 32'd1);
        chk("rereq_rdata", icache_rdata_o, 32'hA1);
        tick();
        chk("rereq_no_300_rvalid", 32'(icache_rvalid_o), 32'd0);
        chk("rereq_noreq", 32'(mem_req_o), 32'd0);
        request(32'h0000_0308);
        chk("rereq_line300_rdata", icache_rdata_o, 32'hC2);
        tick();
        // invalidate
        inv_i = 1'b1;
        tick();
        inv_i = 1'b0;
        request(32'h0000_0104);
        chk("inv_miss_rvalid", 32'(icache_rvalid_o), 32'd0);
        tick();
        chk("inv_memreq", 32'(mem_req_o), 32'd1);
        chk("inv_memaddr", mem_addr_o, 32'h0000_0100);
        grant();
        beat(32'hD0);
        beat(32'hD1);
        beat(32'hD2);
        inv_i = 1'b1;
        beat(32'hD3);
        inv_i = 1'b0;
        chk("inv_last_no_rvalid", 32'(icache_rvalid_o), 32'd0);
        tick();
        chk("inv_last_remiss_req", 32'(mem_req_o), 32'd1);
        chk("inv_last_remiss_addr", mem_addr_o, 32'h0000_0100);
        grant();
        beat(32'hE0);
        beat(32'hE1);
        beat(32'hE2);
        beat(32'hE3);
        chk("inv_refill_rvalid", 32'(icache_rvalid_o), 32'd1);
        chk("inv_refill_rdata", icache_rdata_o, 32'hE1);
        tick();
        // reset mid-refill
        request(32'h0000_0400);
        tick();
        chk("rstfill_memaddr", mem_addr_o, 32'h0000_0400);
        grant();
        beat(32'hF0);
        rst = 1'b1;
        #1;
        chk("rstfill_memreq", 32'(mem_req_o), 32'd0);
        chk("rstfill_memaddr0", mem_addr_o, 32'h0);
        chk("rstfill_rvalid", 32'(icache_rvalid_o), 32'd0);
        tick();
        rst = 1'b0;
        beat(32'hF1);
        chk("rstfill_beat_ignored_req", 32'(mem_req_o), 32'd0);
        chk("rstfill_beat_ignored_rvalid", 32'(icache_rvalid_o), 32'd0);
        request(32'h0000_0100);
        chk("rstfill_new_miss_rvalid", 32'(icache_rvalid_o), 32'd0);
        tick();
        chk("rstfill_new_miss_req", 32'(mem_req_o), 32'd1);
        chk("rstfill_new_miss_addr", mem_addr_o, 32'h0000_0100);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
